// File: rtl/qsys_descriptor_ram_dp.sv
// Dual-port Avalon-MM descriptor RAM (s1 = CPU, s2 = SG-DMA) with clear sequencer.
// Optional DESC_RAM_PARITY_EN: per-byte even parity storage, check and sticky error.
module qsys_descriptor_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  input  logic                    clear_req,
  output logic                    clear_busy
`ifdef DESC_RAM_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NL    = READ_LATENCY;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam state_e ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  stall;

  logic [ADDR_WIDTH-1:0] addr [2];
  logic [NB-1:0]         be   [2];
  logic [DATA_WIDTH-1:0] wd   [2];
  logic [1:0]            cs, rd, wr;
  logic [1:0]            wr_acc, rd_acc;
  logic [NB-1:0]         lane_we [2];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] pd_q [2][NL];
  logic [NL-1:0]         pv_q [2];

  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0]   = s1_byteenable;
  assign be[1]   = s2_byteenable;
  assign wd[0]   = s1_writedata;
  assign wd[1]   = s2_writedata;
  assign cs      = {s2_chipselect, s1_chipselect};
  assign rd      = {s2_read, s1_read};
  assign wr      = {s2_write, s1_write};

  // Waitrequest is a pure function of state so masters never see it
  // react combinationally to their own request.
  assign stall          = (state_q == ST_CLEAR);
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;
  assign clear_busy     = stall;

  // Request acceptance and per-lane write enables; s1 owns contested lanes.
  always_comb begin
    wr_acc     = '0;
    rd_acc     = '0;
    lane_we[0] = '0;
    lane_we[1] = '0;
    for (int p = 0; p < 2; p++) begin
      wr_acc[p] = cs[p] & wr[p] & ~stall;
      rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~stall;
    end
    if (wr_acc[0]) lane_we[0] = be[0];
    if (wr_acc[1]) lane_we[1] = be[1];
    if (wr_acc[0] && (addr[0] == addr[1]))
      lane_we[1] = lane_we[1] & ~be[0];
  end

  // Clear sequencer next state: one word per cycle, DEPTH cycles total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_READY;
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state register; reset restarts any clear from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: clear writes zero, otherwise byte-lane writes.
  always_ff @(posedge clk) begin
    if (stall) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < NB; b++)
          if (lane_we[p][b])
            mem_q[addr[p]][8*b +: 8] <= wd[p][8*b +: 8];
    end
  end

  // Read pipeline; data stages only load on valid so readdata holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        pv_q[p] <= '0;
        for (int s = 0; s < NL; s++) pd_q[p][s] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pv_q[p][0] <= rd_acc[p];
        if (rd_acc[p]) pd_q[p][0] <= mem_q[addr[p]];
        for (int s = 1; s < NL; s++) begin
          pv_q[p][s] <= pv_q[p][s-1];
          if (pv_q[p][s-1]) pd_q[p][s] <= pd_q[p][s-1];
        end
      end
    end
  end

  assign s1_readdata      = pd_q[0][NL-1];
  assign s2_readdata      = pd_q[1][NL-1];
  assign s1_readdatavalid = pv_q[0][NL-1];
  assign s2_readdatavalid = pv_q[1][NL-1];

`ifdef DESC_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] pp_q  [2][NL];
  logic [1:0]    perr_hit;
  logic          parity_err_q;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) r[b] = ^d[8*b +: 8];
    return r;
  endfunction

  // Parity array tracks the data array lane for lane; zero is even parity.
  always_ff @(posedge clk) begin
    if (stall) begin
      par_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < NB; b++)
          if (lane_we[p][b])
            par_q[addr[p]][b] <= ^wd[p][8*b +: 8];
    end
  end

  // Stored parity follows the read data down the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < NL; s++) pp_q[p][s] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) pp_q[p][0] <= par_q[addr[p]];
        for (int s = 1; s < NL; s++)
          if (pv_q[p][s-1]) pp_q[p][s] <= pp_q[p][s-1];
      end
    end
  end

  // Compare recomputed against stored parity as each word is delivered.
  always_comb begin
    perr_hit = '0;
    for (int p = 0; p < 2; p++)
      perr_hit[p] = pv_q[p][NL-1] &
                    (byte_par(pd_q[p][NL-1]) != pp_q[p][NL-1]);
  end

  // Sticky error flag, dropped by reset or a clear request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               parity_err_q <= 1'b0;
    else if (clear_req)      parity_err_q <= 1'b0;
    else if (|perr_hit)      parity_err_q <= 1'b1;
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_qsys_descriptor_ram_dp.sv
// Directed bench for qsys_descriptor_ram_dp (default parameters, READ_LATENCY=1).
// Parity steps are compiled only with DESC_RAM_PARITY_EN.
module tb_qsys_descriptor_ram_dp;

  localparam int LAT = 1;

  logic        clk;
  logic        reset;
  logic [6:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;
  logic        clear_req, clear_busy;
`ifdef DESC_RAM_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int passes = 0;
  int n;
  int seen;

  qsys_descriptor_ram_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .clear_req(clear_req), .clear_busy(clear_busy)
`ifdef DESC_RAM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
    s1_byteenable = 0; s2_byteenable = 0;
    clear_req = 0;
  endtask

  task automatic set_rd(input int p, input logic [6:0] a);
    if (p == 0) begin
      s1_chipselect = 1; s1_read = 1; s1_address = a;
    end else begin
      s2_chipselect = 1; s2_read = 1; s2_address = a;
    end
  endtask

  task automatic set_wr(input int p, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    if (p == 0) begin
      s1_chipselect = 1; s1_write = 1; s1_address = a;
      s1_writedata = d; s1_byteenable = b;
    end else begin
      s2_chipselect = 1; s2_write = 1; s2_address = a;
      s2_writedata = d; s2_byteenable = b;
    end
  endtask

  task automatic write(input int p, input logic [6:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    idle();
    set_wr(p, a, d, b);
    @(negedge clk);
    idle();
  endtask

  task automatic read_chk(input string tag, input int p,
                          input logic [6:0] a, input logic [31:0] exp);
    idle();
    set_rd(p, a);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_valid"}, (p == 0) ? s1_readdatavalid : s2_readdatavalid, 1);
    chk(tag, (p == 0) ? s1_readdata : s2_readdata, exp);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (clear_busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    s1_address = 0; s2_address = 0;
    s1_writedata = 0; s2_writedata = 0;
    idle();
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_wait1", s1_waitrequest, 1);
    chk("rst_wait2", s2_waitrequest, 1);
    chk("rst_busy", clear_busy, 1);
    chk("rst_rdv1", s1_readdatavalid, 0);
    chk("rst_rd1", s1_readdata, 0);
    chk("rst_rd2", s2_readdata, 0);

    reset = 0;
    count_busy(n);
    chk("clr_len", n, 128);
    chk("rdy_wait1", s1_waitrequest, 0);
    chk("rdy_wait2", s2_waitrequest, 0);

    read_chk("clr_00", 0, 7'h00, 32'h0);
    read_chk("clr_7f", 1, 7'h7F, 32'h0);

    write(0, 7'h10, 32'hDEADBEEF, 4'hF);
    read_chk("wr_rd_10", 1, 7'h10, 32'hDEADBEEF);

    idle();
    set_wr(0, 7'h05, 32'h11111111, 4'b0011);
    set_wr(1, 7'h05, 32'h22222222, 4'b0110);
    @(negedge clk);
    read_chk("collide", 0, 7'h05, 32'h00221111);

    write(0, 7'h20, 32'hAAAAAAAA, 4'hF);
    set_wr(0, 7'h20, 32'h55555555, 4'hF);
    set_rd(1, 7'h20);
    @(negedge clk);
    idle();
    set_rd(1, 7'h20);
    chk("mixed_v", s2_readdatavalid, 1);
    chk("mixed_old", s2_readdata, 32'hAAAAAAAA);
    @(negedge clk);
    idle();
    chk("b2b_v", s2_readdatavalid, 1);
    chk("mixed_new", s2_readdata, 32'h55555555);
    @(negedge clk);
    chk("hold_v", s2_readdatavalid, 0);
    chk("hold_d", s2_readdata, 32'h55555555);

    idle();
    set_wr(0, 7'h30, 32'h12345678, 4'hF);
    s1_read = 1;
    @(negedge clk);
    idle();
    chk("rdwr_nov", s1_readdatavalid, 0);
    read_chk("rdwr_data", 0, 7'h30, 32'h12345678);

    write(1, 7'h10, 32'h0, 4'h0);
    read_chk("be0", 1, 7'h10, 32'hDEADBEEF);

    write(0, 7'h40, 32'hCAFEF00D, 4'hF);
    read_chk("raw_same", 0, 7'h40, 32'hCAFEF00D);

    idle();
    clear_req = 1;
    @(negedge clk);
    idle();
    chk("creq_wait", s1_waitrequest, 1);
    set_rd(0, 7'h10);
    n = 0;
    seen = 0;
    while (s1_waitrequest && n < 1000) begin
      @(negedge clk);
      n++;
      if (s1_readdatavalid) seen++;
    end
    chk("creq_len", n, 128);
    chk("creq_stall", seen, 0);
    @(negedge clk);
    idle();
    chk("creq_rd_v", s1_readdatavalid, 1);
    chk("creq_rd_d", s1_readdata, 32'h0);
    read_chk("creq_05", 1, 7'h05, 32'h0);
    read_chk("creq_40", 0, 7'h40, 32'h0);

    write(0, 7'h40, 32'h0BADF00D, 4'hF);
    idle();
    set_rd(0, 7'h40);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_inflight", s1_readdatavalid, 0);
    chk("rst_mid_wait", s1_waitrequest, 1);
    idle();
    @(negedge clk);
    reset = 0;
    repeat (50) @(negedge clk);
    chk("mid_clr_busy", clear_busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    count_busy(n);
    chk("restart_len", n, 128);
    read_chk("restart_40", 0, 7'h40, 32'h0);

`ifdef DESC_RAM_PARITY_EN
    chk("par_init", parity_err, 0);
    write(0, 7'h03, 32'h0000_00F0, 4'hF);
    dut.mem_q[3] = dut.mem_q[3] ^ 32'h1;
    read_chk("par_rd", 1, 7'h03, 32'h0000_00F1);
    @(negedge clk);
    chk("par_set", parity_err, 1);
    @(negedge clk);
    chk("par_sticky", parity_err, 1);
    idle();
    clear_req = 1;
    @(negedge clk);
    idle();
    chk("par_clr", parity_err, 0);
    count_busy(n);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
